// File: rtl/enet_mdio_sched_pkg.sv
// Shared constants for the MDIO scheduler: PHY register map, PHYSTS bit
// positions, scheduler state encodings and the master command record.
package enet_mdio_sched_pkg;

  localparam logic [4:0] REG_BMCR   = 5'h00;
  localparam logic [4:0] REG_BMSR   = 5'h01;
  localparam logic [4:0] REG_PHYSTS = 5'h10;

  localparam int PHYSTS_LINK    = 0;
  localparam int PHYSTS_SPEED10 = 1;
  localparam int PHYSTS_DUPLEX  = 2;

  localparam logic [2:0] S_CFG    = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_CPU    = 3'd2;
  localparam logic [2:0] S_POLL_A = 3'd3;
  localparam logic [2:0] S_POLL_B = 3'd4;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] data;
  } md_cmd_t;

endpackage

// File: rtl/enet_mdio_sched_master.sv
// Single-outstanding Wishbone master towards the MDIO controller.
// Raises cyc+stb on i_start, drops stb once accepted, waits for ack or
// a timeout, then reports o_done for one cycle with the read data.
module mdio_wb_master
  import enet_mdio_sched_pkg::*;
#(
  parameter logic [11:0] TIMEOUT_CYCLES = 12'hfff
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  md_cmd_t     i_cmd,
  output logic        o_md_cyc,
  output logic        o_md_stb,
  output logic        o_md_we,
  output logic [4:0]  o_md_addr,
  output logic [15:0] o_md_data,
  input  logic        i_md_ack,
  input  logic        i_md_stall,
  input  logic [31:0] i_md_data,
  output logic        o_done,
  output logic        o_timeout,
  output logic [15:0] o_rdata
);

  logic [11:0] tmo;
  logic        unused_md_hi;

  // Upper half of the controller data bus carries nothing for us.
  assign unused_md_hi = ^i_md_data[31:16];

  // Transaction handshake, ack wait and timeout countdown.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_md_cyc  <= 1'b0;
      o_md_stb  <= 1'b0;
      o_md_we   <= 1'b0;
      o_md_addr <= '0;
      o_md_data <= '0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      o_rdata   <= '0;
      tmo       <= '0;
    end else begin
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      if (i_start && !o_md_cyc) begin
        o_md_cyc  <= 1'b1;
        o_md_stb  <= 1'b1;
        o_md_we   <= i_cmd.we;
        o_md_addr <= i_cmd.addr;
        o_md_data <= i_cmd.data;
        tmo       <= TIMEOUT_CYCLES;
      end else if (o_md_cyc) begin
        if (o_md_stb && !i_md_stall) o_md_stb <= 1'b0;
        if (i_md_ack) begin
          o_md_cyc <= 1'b0;
          o_md_stb <= 1'b0;
          o_done   <= 1'b1;
          o_rdata  <= i_md_data[15:0];
        end else if (tmo == '0) begin
          // No answer: release the bus and hand back all-ones like a floating MDIO line.
          o_md_cyc  <= 1'b0;
          o_md_stb  <= 1'b0;
          o_done    <= 1'b1;
          o_timeout <= 1'b1;
          o_rdata   <= 16'hffff;
        end else begin
          tmo <= tmo - 12'd1;
        end
      end
    end
  end

endmodule

// File: rtl/enet_mdio_sched.sv
// Shares the MDIO controller between the CPU bus and a PHY link poller.
// Writes BMCR once after reset, then periodically reads BMSR and PHYSTS
// and publishes decoded link status plus a link-change pulse.
module enet_mdio_sched
  import enet_mdio_sched_pkg::*;
#(
  parameter logic [15:0]          INIT_BMCR      = 16'h3100,
  parameter int                   POLL_BITS      = 24,
  parameter logic [POLL_BITS-1:0] POLL_CYCLES    = 24'd10_000_000,
  parameter logic [11:0]          TIMEOUT_CYCLES = 12'hfff
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_addr,
  input  logic [15:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  output logic        o_md_cyc,
  output logic        o_md_stb,
  output logic        o_md_we,
  output logic [4:0]  o_md_addr,
  output logic [15:0] o_md_data,
  input  logic        i_md_ack,
  input  logic        i_md_stall,
  input  logic [31:0] i_md_data,
  output logic [15:0] o_bmsr,
  output logic [15:0] o_physts,
  output logic        o_link_up,
  output logic        o_speed100,
  output logic        o_full_duplex,
  output logic        o_int,
  output logic        o_timeout_err
);

  logic [2:0]           state;
  logic                 issued;     // current state's transaction already launched
  logic                 cpu_live;   // requester still holds its cycle
  md_cmd_t              cpu_cmd;
  md_cmd_t              cmd;
  logic [POLL_BITS-1:0] poll_cnt;
  logic                 poll_due;
  logic                 cpu_req;
  logic                 start;
  logic                 link_prev;
  logic                 m_cyc, m_stb;
  logic                 md_done, md_timeout;
  logic [15:0]          md_rdata;

  assign poll_due   = (poll_cnt == '0);
  assign o_wb_stall = (state != S_IDLE) | (poll_due & ~i_wb_stb);
  assign cpu_req    = i_wb_stb & ~o_wb_stall;
  assign start      = (state != S_IDLE) && !issued;

  // Reset pulls the bus request down immediately, not one edge later.
  assign o_md_cyc = m_cyc & ~i_rst;
  assign o_md_stb = m_stb & ~i_rst;

  assign o_link_up     = o_physts[PHYSTS_LINK];
  assign o_speed100    = o_link_up & ~o_physts[PHYSTS_SPEED10];
  assign o_full_duplex = o_physts[PHYSTS_DUPLEX];

  // Command presented to the master for the transaction owned by the current state.
  always_comb begin
    cmd = '{we: 1'b0, addr: REG_BMCR, data: 16'h0};
    case (state)
      S_CFG:    cmd = '{we: 1'b1, addr: REG_BMCR, data: INIT_BMCR};
      S_CPU:    cmd = cpu_cmd;
      S_POLL_A: cmd.addr = REG_BMSR;
      S_POLL_B: cmd.addr = REG_PHYSTS;
      default:  ;
    endcase
  end

  // Scheduler state, poll timer, CPU response and status caches.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_CFG;
      issued        <= 1'b0;
      cpu_live      <= 1'b0;
      cpu_cmd       <= '0;
      poll_cnt      <= '0;
      o_wb_ack      <= 1'b0;
      o_wb_data     <= '0;
      o_bmsr        <= '0;
      o_physts      <= '0;
      link_prev     <= 1'b0;
      o_int         <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      o_wb_ack <= 1'b0;
      if (start) issued <= 1'b1;
      if (state != S_POLL_A && state != S_POLL_B && poll_cnt != '0)
        poll_cnt <= poll_cnt - POLL_BITS'(1);
      case (state)
        S_CFG: if (md_done) begin
          state  <= S_IDLE;
          issued <= 1'b0;
        end
        S_IDLE: begin
          if (cpu_req) begin
            cpu_cmd  <= '{we: i_wb_we, addr: i_wb_addr, data: i_wb_data};
            cpu_live <= i_wb_cyc;
            state    <= S_CPU;
          end else if (poll_due) begin
            state <= S_POLL_A;
          end
        end
        S_CPU: begin
          if (!i_wb_cyc) cpu_live <= 1'b0;
          if (md_done) begin
            // An abandoned request still finishes on MDIO but gets no ack.
            if (cpu_live && i_wb_cyc) begin
              o_wb_ack  <= 1'b1;
              o_wb_data <= {16'h0, md_rdata};
            end
            state  <= S_IDLE;
            issued <= 1'b0;
          end
        end
        S_POLL_A: if (md_done) begin
          o_bmsr <= md_rdata;
          state  <= S_POLL_B;
          issued <= 1'b0;
        end
        S_POLL_B: if (md_done) begin
          o_physts <= md_rdata;
          poll_cnt <= POLL_CYCLES;
          state    <= S_IDLE;
          issued   <= 1'b0;
        end
        default: state <= S_CFG;
      endcase
      if (md_timeout) o_timeout_err <= 1'b1;
      link_prev <= o_link_up;
      o_int     <= o_link_up ^ link_prev;
    end
  end

  mdio_wb_master #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_master (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (start),
    .i_cmd      (cmd),
    .o_md_cyc   (m_cyc),
    .o_md_stb   (m_stb),
    .o_md_we    (o_md_we),
    .o_md_addr  (o_md_addr),
    .o_md_data  (o_md_data),
    .i_md_ack   (i_md_ack),
    .i_md_stall (i_md_stall),
    .i_md_data  (i_md_data),
    .o_done     (md_done),
    .o_timeout  (md_timeout),
    .o_rdata    (md_rdata)
  );

endmodule

// File: tb/tb_enet_mdio_sched.sv
// Bench for enet_mdio_sched: an MDIO controller model that logs every
// accepted transaction and answers from a register table, plus directed
// and randomized steps checked against expectations derived from the
// scheduler's rules.
module tb_enet_mdio_sched;

  localparam logic [23:0] POLL = 24'd3000;
  localparam int          TMO  = 4095;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [4:0]  i_wb_addr = '0;
  logic [15:0] i_wb_data = '0;
  logic        o_wb_ack, o_wb_stall;
  logic [31:0] o_wb_data;
  logic        o_md_cyc, o_md_stb, o_md_we;
  logic [4:0]  o_md_addr;
  logic [15:0] o_md_data;
  logic        i_md_ack = 1'b0, i_md_stall = 1'b0;
  logic [31:0] i_md_data = '0;
  logic [15:0] o_bmsr, o_physts;
  logic        o_link_up, o_speed100, o_full_duplex, o_int, o_timeout_err;

  enet_mdio_sched #(
    .INIT_BMCR(16'h3100), .POLL_BITS(24), .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(12'hfff)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
    .o_md_cyc(o_md_cyc), .o_md_stb(o_md_stb), .o_md_we(o_md_we),
    .o_md_addr(o_md_addr), .o_md_data(o_md_data),
    .i_md_ack(i_md_ack), .i_md_stall(i_md_stall), .i_md_data(i_md_data),
    .o_bmsr(o_bmsr), .o_physts(o_physts), .o_link_up(o_link_up),
    .o_speed100(o_speed100), .o_full_duplex(o_full_duplex),
    .o_int(o_int), .o_timeout_err(o_timeout_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { bit we; bit [4:0] addr; bit [15:0] data; } txn_t;
  txn_t        txlog[$];
  logic [15:0] rd_val [32];
  int          ack_delay = 600;
  bit          never_ack = 1'b0;
  bit          stall_en  = 1'b0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [4:0]  pend_addr = '0;
  int          cyc_n = 0, int_cnt = 0, ack_cnt = 0;
  int          total = 0, bad = 0;

  // Controller model: accept, log, answer after ack_delay cycles (or never).
  always @(posedge i_clk) begin
    i_md_ack   <= 1'b0;
    i_md_stall <= stall_en && ($urandom_range(0, 3) == 0);
    if (i_rst || !o_md_cyc) pend <= 1'b0;
    if (!i_rst && o_md_cyc && o_md_stb && !i_md_stall) begin
      txlog.push_back('{o_md_we, o_md_addr, o_md_data});
      pend      <= 1'b1;
      cnt       <= ack_delay;
      pend_addr <= o_md_addr;
    end else if (!i_rst && pend && o_md_cyc) begin
      if (cnt == 0) begin
        if (!never_ack) begin
          i_md_ack  <= 1'b1;
          i_md_data <= {16'($urandom()), rd_val[pend_addr]};
          pend      <= 1'b0;
        end
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  always @(posedge i_clk) cyc_n <= cyc_n + 1;

  // Count link-change pulses and CPU acks between edges.
  always @(negedge i_clk) begin
    if (o_int)    int_cnt <= int_cnt + 1;
    if (o_wb_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expired(input string tag);
    total++;
    bad++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (txlog.size() >= n) ok = 1'b1;
      else @(negedge i_clk);
    end
    if (!ok) expired(tag);
  endtask

  task automatic wait_md_idle(input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (!o_md_cyc) ok = 1'b1;
      else @(negedge i_clk);
    end
    if (!ok) expired(tag);
  endtask

  task automatic wait_round(input int n, input string tag);
    wait_log(n, 8000, tag);
    wait_md_idle(2000, tag);
    tick(4);
  endtask

  task automatic cpu_issue(input bit we, input logic [4:0] a, input logic [15:0] d,
                           output int t_acc);
    bit ok = 1'b0;
    t_acc = 0;
    @(posedge i_clk); #1;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we; i_wb_addr = a; i_wb_data = d;
    for (int i = 0; i < 12000 && !ok; i++) begin
      @(negedge i_clk);
      if (!o_wb_stall) begin
        ok = 1'b1;
        @(posedge i_clk); #1;
        i_wb_stb = 1'b0;
        t_acc = cyc_n;
      end
    end
    if (!ok) begin
      expired("cpu_accept");
      i_wb_stb = 1'b0;
    end
  endtask

  task automatic cpu_wait_ack(output logic [31:0] d, output int t);
    bit ok = 1'b0;
    d = 'x;
    t = 0;
    for (int i = 0; i < 12000 && !ok; i++) begin
      @(negedge i_clk);
      if (o_wb_ack) begin
        ok = 1'b1;
        d = o_wb_data;
        t = cyc_n;
      end
    end
    if (!ok) expired("cpu_ack");
    @(posedge i_clk); #1;
    i_wb_cyc = 1'b0;
  endtask

  function automatic logic [21:0] log_at(input int i);
    if (i < txlog.size()) return {txlog[i].we, txlog[i].addr, txlog[i].data};
    return 'x;
  endfunction

  function automatic logic [5:0] log_hdr(input int i);
    if (i < txlog.size()) return {txlog[i].we, txlog[i].addr};
    return 'x;
  endfunction

  // Expected decoded status for a PHYSTS value.
  task automatic chk_status(input string tag, input logic [15:0] v, input logic [15:0] bmsr,
                            inout logic exp_link, inout int exp_int);
    chk({tag, "_physts"}, 32'(o_physts), 32'(v));
    chk({tag, "_bmsr"},   32'(o_bmsr),   32'(bmsr));
    chk({tag, "_decode"}, 32'({o_link_up, o_speed100, o_full_duplex}),
        32'({v[0], v[0] & ~v[1], v[2]}));
    if (v[0] != exp_link) exp_int++;
    exp_link = v[0];
    chk({tag, "_int"}, 32'(int_cnt), 32'(exp_int));
  endtask

  initial begin
    logic [31:0] d;
    logic [15:0] v, wd;
    logic        exp_link;
    int          exp_int, t0, t1, base, ack0;
    exp_link = 1'b0;
    exp_int  = 0;
    foreach (rd_val[k]) rd_val[k] = 16'($urandom());
    rd_val[5'h01] = 16'h7849;
    rd_val[5'h10] = 16'h0005;
    rd_val[5'h02] = 16'h2000;

    // Reset state.
    tick(5);
    chk("rst_ctl", 32'({o_md_cyc, o_md_stb, o_wb_ack, o_int, o_timeout_err,
                        o_link_up, o_speed100, o_full_duplex}), 32'h0);
    chk("rst_bmsr", 32'(o_bmsr), 32'h0);
    chk("rst_physts", 32'(o_physts), 32'h0);
    chk("rst_wbdata", o_wb_data, 32'h0);
    @(posedge i_clk); #1 i_rst = 1'b0;

    // Boot: BMCR write then an immediate poll round, slow controller.
    wait_round(3, "boot");
    chk("boot_bmcr", 32'(log_at(0)), 32'({1'b1, 5'h00, 16'h3100}));
    chk("boot_rd_bmsr", 32'(log_hdr(1)), 32'({1'b0, 5'h01}));
    chk("boot_rd_physts", 32'(log_hdr(2)), 32'({1'b0, 5'h10}));
    chk("boot_count", 32'(txlog.size()), 32'd3);
    chk_status("boot", 16'h0005, 16'h7849, exp_link, exp_int);

    // Link goes down on the next periodic round, controller stalls randomly.
    stall_en  = 1'b1;
    ack_delay = $urandom_range(0, 15);
    rd_val[5'h10] = 16'h0006;
    base = txlog.size();
    wait_round(base + 2, "down");
    chk("down_rd_bmsr", 32'(log_hdr(base)), 32'({1'b0, 5'h01}));
    chk("down_rd_physts", 32'(log_hdr(base + 1)), 32'({1'b0, 5'h10}));
    chk_status("down", 16'h0006, 16'h7849, exp_link, exp_int);

    // Random PHY status values across further rounds.
    for (int r = 0; r < 4; r++) begin
      v = 16'($urandom());
      rd_val[5'h10] = v;
      rd_val[5'h01] = 16'($urandom());
      ack_delay = $urandom_range(0, 15);
      base = txlog.size();
      wait_round(base + 2, "rand");
      chk_status("rand", v, rd_val[5'h01], exp_link, exp_int);
    end

    // CPU read lands on the very cycle the poll timer expires.
    stall_en  = 1'b0;
    ack_delay = 10;
    base = txlog.size();
    wait_log(base + 2, 8000, "align");
    wait_md_idle(200, "align");
    tick(POLL);
    base = txlog.size();
    cpu_issue(1'b0, 5'h02, 16'h0, t0);
    cpu_wait_ack(d, t1);
    chk("prio_data", d, 32'h0000_2000);
    wait_round(base + 3, "prio");
    chk("prio_first_cpu", 32'(log_hdr(base)), 32'({1'b0, 5'h02}));
    chk("prio_then_bmsr", 32'(log_hdr(base + 1)), 32'({1'b0, 5'h01}));
    chk("prio_then_physts", 32'(log_hdr(base + 2)), 32'({1'b0, 5'h10}));

    // Controller never answers a CPU read.
    never_ack = 1'b1;
    cpu_issue(1'b0, 5'h03, 16'h0, t0);
    cpu_wait_ack(d, t1);
    never_ack = 1'b0;
    chk("tmo_data", d, 32'h0000_ffff);
    chk("tmo_err", 32'(o_timeout_err), 32'h1);
    chk("tmo_latency", 32'((t1 - t0) >= TMO && (t1 - t0) <= TMO + 10), 32'h1);
    cpu_issue(1'b0, 5'h02, 16'h0, t0);
    cpu_wait_ack(d, t1);
    chk("tmo_recover", d, 32'h0000_2000);
    chk("tmo_sticky", 32'(o_timeout_err), 32'h1);

    // Reset while a CPU write waits for its ack.
    ack_delay = 200;
    wd = 16'($urandom());
    cpu_issue(1'b1, 5'h04, wd, t0);
    base = txlog.size();
    wait_log(base + 1, 500, "rstw");
    chk("rstw_write", 32'(log_at(base)), 32'({1'b1, 5'h04, wd}));
    tick(5);
    ack0 = ack_cnt;
    @(posedge i_clk); #1 i_rst = 1'b1;
    #1 chk("rstw_cyc_drop", 32'(o_md_cyc), 32'h0);
    tick(3);
    chk("rstw_physts", 32'(o_physts), 32'h0);
    chk("rstw_err_clr", 32'(o_timeout_err), 32'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_wb_cyc = 1'b0;
    exp_link = 1'b0;
    ack_delay = 5;
    base = txlog.size();
    wait_round(base + 3, "rstw_boot");
    chk("rstw_bmcr", 32'(log_at(base)), 32'({1'b1, 5'h00, 16'h3100}));
    chk("rstw_no_ack", 32'(ack_cnt), 32'(ack0));
    chk_status("rstw", rd_val[5'h10], rd_val[5'h01], exp_link, exp_int);

    // CPU abandons a read mid-flight.
    ack_delay = 50;
    ack0 = ack_cnt;
    cpu_issue(1'b0, 5'h02, 16'h0, t0);
    base = txlog.size();
    wait_log(base + 1, 500, "drop");
    tick(5);
    i_wb_cyc = 1'b0;
    wait_md_idle(500, "drop");
    tick(5);
    chk("drop_rd", 32'(log_hdr(base)), 32'({1'b0, 5'h02}));
    chk("drop_no_ack", 32'(ack_cnt), 32'(ack0));
    chk("drop_data_held", o_wb_data, 32'h0);
    cpu_issue(1'b0, 5'h01, 16'h0, t0);
    cpu_wait_ack(d, t1);
    chk("drop_next", d, {16'h0, rd_val[5'h01]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
